reciprocal_nr_seq: RTL and testbench

Sequential, parametrised Newton-Raphson mantissa reciprocal unit for the bfloat16 divide path. It accepts a normalised Q1.(W-1) mantissa over a valid/ready handshake and computes its reciprocal. One NR step runs per clock, for a configurable iteration count, using guard bits. It returns a rounded Q1.(W-1) result and an error flag. It replaces the fixed 8-bit combinational reciprocal and feeds the divider's mantissa multiplier, which multiplies the dividend by the reciprocal.

---
 rtl/reciprocal_nr_seq_if.sv | 23 ++
 rtl/reciprocal_nr_seq.sv | 108 ++++++++++
 tb/tb_reciprocal_nr_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reciprocal_nr_seq_if.sv
// Operand/result handshake bundle for the Newton-Raphson mantissa reciprocal unit.
// master = producer/consumer side, slave = the reciprocal unit.
interface reciprocal_nr_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_mant;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r_mant;
  logic         err;

  modport master (
    output in_valid, a_mant, out_ready,
    input  in_ready, out_valid, r_mant, err
  );

  modport slave (
    input  in_valid, a_mant, out_ready,
    output in_ready, out_valid, r_mant, err
  );
endinterface

// File: rtl/reciprocal_nr_seq.sv
// Sequential Newton-Raphson reciprocal of a normalised Q1.(W-1) mantissa.
// One NR step per clock on a guard-extended Q1.F datapath, rounded back to W bits.
module reciprocal_nr_seq #(
  parameter int W     = 8,
  parameter int ITERS = 3,
  parameter int G     = 4
) (
  input  logic                clk,
  input  logic                rst,
  reciprocal_nr_seq_if.slave  io
);
  localparam int F  = W - 1 + G;
  localparam int CW = (ITERS < 2) ? 1 : $clog2(ITERS);

  localparam logic [F+1:0] TWO_F   = (F+2)'(2) << F;
  localparam logic [F+1:0] THREE_F = (F+2)'(3) << F;
  localparam logic [F+2:0] ONE_X   = (F+3)'(1) << F;
  localparam logic [F+1:0] RND     = (F+2)'(1) << (G-1);
  localparam logic [F+1:0] RMAX    = (F+2)'(1) << (W-1);
  localparam logic [CW-1:0] LAST   = CW'(ITERS-1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t        state_q;
  logic [F:0]    ae_q, x_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q, out_valid_q, err_q;
  logic [W-1:0]  r_mant_q;

  logic [F:0]     ae_d, seed_d, x_d;
  logic [F+1:0]   sd_full, t, d, rsum, rsh;
  logic [2*F+1:0] p;
  logic [2*F+2:0] q;
  logic [F+2:0]   xs;
  logic [W-1:0]   r_d;

  // Seed and one NR step: x' = x * (2 - Ae*x), both products truncated to F fraction bits.
  always_comb begin
    ae_d    = {io.a_mant, {G{1'b0}}};
    sd_full = THREE_F - {1'b0, ae_d};
    seed_d  = (F+1)'(sd_full >> 1);
    p       = {{(F+1){1'b0}}, ae_q} * {{(F+1){1'b0}}, x_q};
    t       = (F+2)'(p >> F);
    d       = TWO_F - t;
    q       = {{(F+2){1'b0}}, x_q} * {{(F+1){1'b0}}, d};
    xs      = (F+3)'(q >> F);
    x_d     = (xs > ONE_X) ? ONE_X[F:0] : xs[F:0];
    rsum    = {1'b0, x_d} + RND;
    rsh     = rsum >> G;
    r_d     = (rsh > RMAX) ? RMAX[W-1:0] : rsh[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ae_q        <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_mant_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            in_ready_q <= 1'b0;
            if (io.a_mant[W-1]) begin
              ae_q    <= ae_d;
              x_q     <= seed_d;
              cnt_q   <= '0;
              state_q <= S_ITER;
            end else begin
              r_mant_q    <= '1;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_ITER: begin
          x_q   <= x_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            r_mant_q    <= r_d;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset also masks readiness so nothing can be accepted while it is held.
  assign io.in_ready  = in_ready_q & ~rst;
  assign io.out_valid = out_valid_q;
  assign io.r_mant    = r_mant_q;
  assign io.err       = err_q;
endmodule

// File: tb/tb_reciprocal_nr_seq.sv
// Randomised self-checking bench for reciprocal_nr_seq (W=8/ITERS=3 and W=16/ITERS=4)
// against a plain-arithmetic reference of the NR recurrence.
module tb_reciprocal_nr_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  reciprocal_nr_seq_if #(.W(8))  i8  ();
  reciprocal_nr_seq_if #(.W(16)) i16 ();

  reciprocal_nr_seq #(.W(8),  .ITERS(3), .G(4)) dut8  (.clk(clk), .rst(rst), .io(i8.slave));
  reciprocal_nr_seq #(.W(16), .ITERS(4), .G(4)) dut16 (.clk(clk), .rst(rst), .io(i16.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: seed, ITERS Newton steps, round-to-nearest back to W bits.
  function automatic int unsigned ref_recip(int w, int g, int iters, int unsigned a);
    longint unsigned f, ae, x, p, t, d, q, one, mask2, r, rmax;
    if (((a >> (w-1)) & 1) == 0) return (1 << w) - 1;
    f     = w - 1 + g;
    ae    = longint'(a) << g;
    one   = 64'd1 << f;
    mask2 = (64'd1 << (f + 2)) - 1;
    x     = ((64'd3 << f) - ae) >> 1;
    for (int i = 0; i < iters; i++) begin
      p = ae * x;
      t = (p >> f) & mask2;
      d = ((64'd2 << f) - t) & mask2;
      q = x * d;
      x = q >> f;
      if (x > one) x = one;
    end
    r    = (x + (64'd1 << (g - 1))) >> g;
    rmax = 64'd1 << (w - 1);
    if (r > rmax) r = rmax;
    return int'(r);
  endfunction

  function automatic logic rdy(input bit wide);
    return wide ? i16.in_ready : i8.in_ready;
  endfunction
  function automatic logic ov(input bit wide);
    return wide ? i16.out_valid : i8.out_valid;
  endfunction
  function automatic logic [15:0] rm(input bit wide);
    return wide ? i16.r_mant : {8'h00, i8.r_mant};
  endfunction
  function automatic logic er(input bit wide);
    return wide ? i16.err : i8.err;
  endfunction

  // One operation: accept, wait for result, optional backpressure, then handshake.
  task automatic op(input bit wide, input logic [15:0] a, input int hold,
                    output logic [15:0] r, output logic e, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!rdy(wide) && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("in_ready_timeout", 0, 1);
    if (wide) begin i16.in_valid = 1'b1; i16.a_mant = a; end
    else      begin i8.in_valid  = 1'b1; i8.a_mant  = a[7:0]; end
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i16.in_valid = 1'b0;
    chk("in_ready_after_accept", rdy(wide), 0);
    lat = 0;
    while (!ov(wide) && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) chk("out_valid_timeout", 0, 1);
    r = rm(wide);
    e = er(wide);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", ov(wide), 1);
      chk("hold_r_mant", rm(wide), r);
      chk("hold_err", er(wide), e);
      chk("hold_in_ready", rdy(wide), 0);
    end
    i8.out_ready = ~wide; i16.out_ready = wide;
    @(posedge clk); #1;
    i8.out_ready = 1'b0; i16.out_ready = 1'b0;
    chk("idle_after_handshake", {ov(wide), rdy(wide)}, 2'b01);
  endtask

  initial begin
    logic [15:0] r;
    logic        e;
    int          lat, seen;
    int          perm[128];
    logic [15:0] a16;

    i8.in_valid = 0;  i8.a_mant = '0;  i8.out_ready = 0;
    i16.in_valid = 0; i16.a_mant = '0; i16.out_ready = 0;

    #2;
    chk("reset_in_ready", i8.in_ready, 0);
    chk("reset_out_valid", i8.out_valid, 0);
    chk("reset_r_mant", i8.r_mant, 0);
    chk("reset_err", i8.err, 0);
    chk("reset16_outputs", {i16.out_valid, i16.err, i16.r_mant}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("in_ready_after_reset", i8.in_ready, 1);

    // Directed points
    op(0, 16'h80, 0, r, e, lat);
    chk("one_r", r, 16'h80); chk("one_err", e, 0); chk("one_latency", lat, 3);
    op(0, 16'hC0, 0, r, e, lat);
    chk("two_thirds_r", r, 16'h55); chk("two_thirds_err", e, 0);
    op(0, 16'hFF, 0, r, e, lat);
    chk("near_two_r", r, 16'h40); chk("near_two_err", e, 0);
    // Error result is registered at the accept edge itself.
    op(0, 16'h40, 0, r, e, lat);
    chk("err40_r", r, 16'hFF); chk("err40_err", e, 1); chk("err40_latency", lat, 0);
    op(0, 16'h00, 0, r, e, lat);
    chk("err00_r", r, 16'hFF); chk("err00_err", e, 1);

    // Backpressure, then back-to-back operand at the earliest slot
    op(0, 16'h80, 5, r, e, lat);
    chk("bp_r", r, 16'h80);
    op(0, 16'hC0, 0, r, e, lat);
    chk("b2b_r", r, 16'h55); chk("b2b_latency", lat, 3);

    // Asynchronous reset during the second iteration cycle
    @(negedge clk);
    i8.in_valid = 1'b1; i8.a_mant = 8'hC0;
    @(posedge clk); #1 i8.in_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst_out", {i8.out_valid, i8.err, i8.r_mant}, 0);
    chk("midrst_in_ready", i8.in_ready, 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i8.out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    op(0, 16'h80, 0, r, e, lat);
    chk("post_rst_r", r, 16'h80); chk("post_rst_err", e, 0);

    // All 128 normalised W=8 inputs in shuffled order
    for (int i = 0; i < 128; i++) perm[i] = 128 + i;
    for (int i = 127; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 128; i++) begin
      op(0, 16'(perm[i]), (i % 17 == 0) ? 2 : 0, r, e, lat);
      chk("sweep8_r", r, ref_recip(8, 4, 3, perm[i]));
      chk("sweep8_err", e, 0);
    end

    // W=16, ITERS=4 random operands, a few non-normalised
    for (int i = 0; i < 128; i++) begin
      a16 = 16'($urandom);
      if (i % 16 != 5) a16[15] = 1'b1;
      op(1, a16, 0, r, e, lat);
      chk("sweep16_r", r, ref_recip(16, 4, 4, a16));
      chk("sweep16_err", e, !a16[15]);
      chk("sweep16_latency", lat, a16[15] ? 4 : 0);
    end
    op(1, 16'h8000, 0, r, e, lat);
    chk("w16_one", r, 16'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
